// File: rtl/memory_access_ctrl.sv
// Memory access controller: accepts a single read/write request, drives the
// memory interface for WAIT_CYCLES+1 cycles and returns a one-cycle ack/err.
module memory_access_ctrl #(
   parameter int              DATA_W      = 8,
   parameter int              ADDR_W      = 8,
   parameter int              WAIT_CYCLES = 2,
   parameter longint unsigned ADDR_MAX    = (64'd1 << ADDR_W) - 64'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t     state;
   logic [3:0] cnt;
   logic       we_q;
   logic       in_range;

   assign in_range = (64'(addr_in) <= ADDR_MAX);
   assign busy     = (state != IDLE);

   // NOTE: all state and outputs update with non-blocking assignments so every
   // register sees the pre-edge values of its peers, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         rdata     <= '0;
         ack       <= 1'b0;
         err       <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  we_q <= we;
                  cnt  <= 4'd0;
                  if (in_range) begin
                     state     <= ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= we;
                     mem_addr  <= addr_in;
                     mem_wdata <= wdata;
                  end else begin
                     // Out-of-range: skip the memory entirely, report at once.
                     state <= DONE;
                     ack   <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (cnt == WAIT_LAST) begin
                  state  <= DONE;
                  ack    <= 1'b1;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (!we_q) rdata <= mem_rdata;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/memory_access_ctrl.md
MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 8, the data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, the address bus width in bits.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, the number of extra memory wait cycles per access (legal range 0..15).
REQ-004 The block SHALL have parameter ADDR_MAX, default 2**ADDR_W-1, the highest legal address.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req, input, 1 bit: access request from the control unit.
REQ-008 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-009 The block SHALL have port addr_in, input, ADDR_W bits: access address; sampled with req.
REQ-010 The block SHALL have port wdata, input, DATA_W bits: write data; sampled with req.
REQ-011 The block SHALL have port rdata, output, DATA_W bits: registered read data.
REQ-012 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit: valid with ack; 1 = address out of range.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-015 The block SHALL have port mem_en, output, 1 bit: memory enable.
REQ-016 The block SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-017 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-018 The block SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-019 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data.
REQ-020 No port SHALL be bidirectional; the read and write paths are separate.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ACCESS and DONE.
REQ-022 In IDLE with req=1, the rising edge SHALL latch we, addr_in and wdata into internal registers and clear the wait counter.
REQ-023 On that same edge, if the latched address is <= ADDR_MAX the next state SHALL be ACCESS; otherwise it SHALL be DONE with err=1.
REQ-024 In ACCESS, mem_en SHALL be 1, mem_we SHALL equal the latched we, and mem_addr and mem_wdata SHALL hold the latched values, stable for the whole access.
REQ-025 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit counter; on the edge where counter == WAIT_CYCLES the next state SHALL be DONE.
REQ-026 On a read, rdata SHALL be loaded from mem_rdata on the edge leaving ACCESS; on a write, rdata SHALL be unchanged.
REQ-027 In DONE, ack SHALL be 1 for exactly one cycle, err SHALL be valid, and the next state SHALL be IDLE unconditionally.
REQ-028 Outside ACCESS: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
REQ-029 Latency SHALL be as follows: for an in-range access, ack is high in the (WAIT_CYCLES+2)th cycle after the accepting edge; for an out-of-range access, ack is high in the 1st cycle after it.
REQ-030 req SHALL be ignored while busy=1, so no request is queued; a req still high in IDLE after DONE SHALL start a new access, giving a minimum of one idle cycle between accesses.
REQ-031 An out-of-range access SHALL never assert mem_en or mem_we, and SHALL leave rdata unchanged.
REQ-032 err SHALL be 0 whenever ack is 0.
REQ-033 When WAIT_CYCLES=0, ACCESS SHALL last exactly one cycle.
REQ-034 The block SHALL not decode or stall on any address wrap-around; mem_addr SHALL equal the latched addr_in exactly.

Reset
REQ-035 While rst_n=0, asynchronously: state=IDLE, counter=0, rdata=0, ack=0, err=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 Assertion of rst_n mid-ACCESS SHALL drop mem_en and mem_we immediately, with no ack for the aborted access.
REQ-037 The first req SHALL be sampled on the first rising edge after rst_n deasserts.

Verification
REQ-038 Test: after reset, drive req=1, we=1, addr_in=0x10, wdata=0xA5 for one cycle -> mem_en=mem_we=1 for 3 cycles at addr 0x10 with data 0xA5, then ack=1 and err=0 for 1 cycle.
REQ-039 Test: read addr 0x10 while memory returns 0xA5 -> mem_we=0, rdata=0xA5 when ack=1, with ack in the 4th cycle after the accepting edge.
REQ-040 Test: with ADDR_MAX=0x7F, read addr 0x80 -> mem_en stays 0, ack=1 and err=1 in the next cycle, rdata unchanged.
REQ-041 Test: hold req=1 continuously for 3 reads -> exactly 3 ack pulses, with busy low for exactly 1 cycle between accesses and no request accepted while busy=1.
REQ-042 Test: pulse rst_n=0 during the 2nd ACCESS cycle -> mem_en=0 at once, no ack, all outputs 0, and the next req is serviced normally.
REQ-043 Test: with WAIT_CYCLES=0 and DATA_W=16, write 0xBEEF then read it back -> mem_en high for 1 cycle per access, rdata=0xBEEF.
